serial_frame_loader: RTL and testbench
======================================

SERIAL_FRAME_LOADER -- requirements
Module: serial_frame_loader

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
  CLKS_PER_BIT  434  clk cycles per UART bit (minimum 4)
  DATA_W        8    UART data bits per character and RAM word width
  FRAME_LEN     80   characters per frame
  NUM_FRAMES    4    frames stored before full; DEPTH = FRAME_LEN*NUM_FRAMES
  ADDR_W        9    read/write address width; ADDR_W >= clog2(DEPTH)
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
  clk          in   1                        single clock, rising edge
  rst          in   1                        asynchronous, active-low reset
  RxD          in   1                        UART serial input, idle high
  rearm        in   1                        one-cycle pulse: restart loading at address 0
  addr         in   ADDR_W                   RAM read address
  GPout        out  DATA_W                   registered read data
  RAM_full     out  1                        all DEPTH words written
  frame_cnt    out  clog2(NUM_FRAMES+1)      completed frames since reset or rearm
  frame_err    out  1                        sticky: stop bit sampled low
  overflow     out  1                        sticky: character arrived while RAM_full

Function
REQ-003 RxD SHALL pass through a 2-flop synchroniser before any use.
REQ-004 Receiver: falling edge in IDLE -> START; start bit re-sampled at CLKS_PER_BIT/2, high -> IDLE (glitch), low -> DATA; DATA_W bits sampled LSB first every CLKS_PER_BIT at mid-bit; then STOP sampled once.
REQ-005 Receiver SHALL pulse rx_valid for exactly one cycle after the stop sample, with rx_err=1 when the stop bit is low.
REQ-006 Loader FSM states SHALL be LOAD and FULL; reset enters LOAD with wr_ptr=0.
REQ-007 In LOAD, rx_valid with rx_err=0 SHALL write rx_data to mem[wr_ptr] and increment wr_ptr in the same cycle.
REQ-008 rx_valid with rx_err=1 SHALL set frame_err and SHALL NOT write or advance wr_ptr.
REQ-009 frame_cnt SHALL increment on the write that makes wr_ptr a multiple of FRAME_LEN.
REQ-010 The write to address DEPTH-1 SHALL move LOAD->FULL and assert RAM_full on the next cycle; wr_ptr SHALL NOT wrap.
REQ-011 In FULL, any rx_valid SHALL be discarded and SHALL set overflow; memory is unchanged.
REQ-012 rearm in any state SHALL clear wr_ptr, frame_cnt, RAM_full, frame_err and overflow and enter LOAD; memory contents are kept.
REQ-013 rearm coincident with rx_valid SHALL take priority; the character is discarded and no flag is set.
REQ-014 GPout SHALL equal mem[addr] one cycle after addr is presented, in any FSM state.
REQ-015 A read and a write to the same address in the same cycle SHALL return the old data.
REQ-016 An addr >= DEPTH SHALL return 0 on GPout.

Reset
REQ-017 rst low SHALL asynchronously force: receiver IDLE, synchroniser flops 1, loader LOAD, wr_ptr 0, GPout 0, RAM_full 0, frame_cnt 0, frame_err 0, overflow 0.
REQ-018 Memory contents SHALL NOT be reset; reset in mid-character SHALL abandon the character with no write.
REQ-019 Deassertion of rst SHALL be synchronised before use as the reset of the FSM flops.

Structure
REQ-020 The shared package SHALL hold the receiver and loader state encodings and the default CLKS_PER_BIT, DATA_W, FRAME_LEN and NUM_FRAMES values.
REQ-021 The receiver SHALL be one sub-module, uart_rx_core (ports: clk, rst, RxD, rx_valid, rx_data, rx_err); loader FSM and memory stay in the top level.

Verification
Bench settings: CLKS_PER_BIT=4, FRAME_LEN=4, NUM_FRAMES=2.
REQ-022 Send 0xA5 -> one rx_valid pulse; addr=0 then GPout=0xA5 on the next cycle; frame_cnt=0.
REQ-023 Send 0x00..0x07 -> frame_cnt 1 after the 4th character and 2 after the 8th; RAM_full=1; addr 0..7 read back 0x00..0x07.
REQ-024 When full, send 0xFF -> overflow=1; addr=0 still reads 0x00.
REQ-025 Send 0x3C with stop bit forced low -> frame_err=1; wr_ptr and memory unchanged; the next good 0x11 is written at the same address.
REQ-026 rearm on the same cycle as rx_valid -> all flags and counters 0, character not written; the next 0x22 is written to addr 0.
REQ-027 Pull rst low mid-character -> all outputs 0 within the reset; a clean 0x5A after release is written to addr 0.

Source files
------------

// File: rtl/serial_frame_loader_pkg.sv
// Shared definitions for the serial frame loader: receiver and loader state
// encodings plus the default configuration values.
package serial_frame_loader_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 434;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_FRAME_LEN    = 80;
  localparam int unsigned DEF_NUM_FRAMES   = 4;

  // UART receiver states
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Frame loader states
  typedef enum logic {
    LD_LOAD,
    LD_FULL
  } ld_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: 8N1-style framing, LSB first, mid-bit sampling.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   RxD      - serial input, idle high (synchronised internally)
//   rx_valid - one-cycle pulse after the stop bit is sampled
//   rx_data  - received character, valid with rx_valid
//   rx_err   - stop bit was sampled low, valid with rx_valid
module uart_rx_core
  import serial_frame_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RxD,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  rx_state_t         state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [BIT_W-1:0]  bit_idx, bit_idx_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [DATA_W-1:0] rx_data_d;
  logic              rx_valid_d, rx_err_d;
  logic              rxd_meta, rxd_sync, rxd_prev;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      rx_err   <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      rx_valid <= rx_valid_d;
      rx_data  <= rx_data_d;
      rx_err   <= rx_err_d;
    end
  end

  // Next-state: the cycle counter restarts at every sampling point
  always_comb begin
    state_d    = state;
    cnt_d      = cnt + CNT_W'(1);
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    rx_valid_d = 1'b0;
    rx_data_d  = rx_data;
    rx_err_d   = rx_err;
    unique case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (rxd_prev && !rxd_sync) state_d = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A start bit that is high again at mid-bit was a glitch
          state_d   = rxd_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == CNT_BIT) begin
          cnt_d   = '0;
          shift_d = {rxd_sync, shift[DATA_W-1:1]};
          if (bit_idx == BIT_LAST) state_d = RX_STOP;
          else bit_idx_d = bit_idx + BIT_W'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CNT_BIT) begin
          cnt_d      = '0;
          rx_valid_d = 1'b1;
          rx_err_d   = !rxd_sync;
          rx_data_d  = shift;
          state_d    = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/serial_frame_loader.sv
// Serial frame loader: receives UART characters and stores them sequentially
// into a DEPTH-word RAM until full; RAM is readable at any time.
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   RxD       - UART serial input, idle high
//   rearm     - one-cycle pulse: restart loading at address 0 (RAM kept)
//   addr      - RAM read address
//   GPout     - registered read data (0 for addr >= DEPTH)
//   RAM_full  - all DEPTH words written
//   frame_cnt - completed frames since reset or rearm
//   frame_err - sticky: a character had its stop bit low
//   overflow  - sticky: a character arrived while RAM_full
module serial_frame_loader
  import serial_frame_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned FRAME_LEN    = DEF_FRAME_LEN,
  parameter int unsigned NUM_FRAMES   = DEF_NUM_FRAMES,
  parameter int unsigned ADDR_W       = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              RxD,
  input  logic                              rearm,
  input  logic [ADDR_W-1:0]                 addr,
  output logic [DATA_W-1:0]                 GPout,
  output logic                              RAM_full,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_cnt,
  output logic                              frame_err,
  output logic                              overflow
);

  localparam int unsigned DEPTH  = FRAME_LEN * NUM_FRAMES;
  localparam int unsigned MEM_AW = $clog2(DEPTH);
  localparam int unsigned POS_W  = $clog2(FRAME_LEN + 1);
  localparam int unsigned FC_W   = $clog2(NUM_FRAMES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [POS_W-1:0]  LAST_POS  = POS_W'(FRAME_LEN - 1);

  logic [1:0]        rst_pipe;
  logic              rst_n_sync;
  logic              rx_valid, rx_err;
  logic [DATA_W-1:0] rx_data;
  logic [DATA_W-1:0] mem [DEPTH];

  ld_state_t         ld_state, ld_state_d;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [POS_W-1:0]  frame_pos, frame_pos_d;
  logic [FC_W-1:0]   frame_cnt_d;
  logic              ram_full_d, frame_err_d, overflow_d;
  logic              we_c;

  // Reset asserts asynchronously, deasserts two clocks after rst rises
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_pipe <= '0;
    else      rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n_sync = rst_pipe[1];

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .DATA_W       (DATA_W)
  ) u_rx (
    .clk      (clk),
    .rst      (rst_n_sync),
    .RxD      (RxD),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_err   (rx_err)
  );

  // Loader registers
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      ld_state  <= LD_LOAD;
      wr_ptr    <= '0;
      frame_pos <= '0;
      frame_cnt <= '0;
      RAM_full  <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      ld_state  <= ld_state_d;
      wr_ptr    <= wr_ptr_d;
      frame_pos <= frame_pos_d;
      frame_cnt <= frame_cnt_d;
      RAM_full  <= ram_full_d;
      frame_err <= frame_err_d;
      overflow  <= overflow_d;
    end
  end

  // Loader next-state; rearm overrides any character arriving the same cycle
  always_comb begin
    ld_state_d  = ld_state;
    wr_ptr_d    = wr_ptr;
    frame_pos_d = frame_pos;
    frame_cnt_d = frame_cnt;
    ram_full_d  = RAM_full;
    frame_err_d = frame_err;
    overflow_d  = overflow;
    we_c        = 1'b0;
    if (rearm) begin
      ld_state_d  = LD_LOAD;
      wr_ptr_d    = '0;
      frame_pos_d = '0;
      frame_cnt_d = '0;
      ram_full_d  = 1'b0;
      frame_err_d = 1'b0;
      overflow_d  = 1'b0;
    end else if (rx_valid) begin
      unique case (ld_state)
        LD_LOAD: begin
          if (rx_err) begin
            frame_err_d = 1'b1;
          end else begin
            we_c = 1'b1;
            if (frame_pos == LAST_POS) begin
              frame_pos_d = '0;
              frame_cnt_d = frame_cnt + FC_W'(1);
            end else begin
              frame_pos_d = frame_pos + POS_W'(1);
            end
            // Pointer parks on the last address rather than wrapping
            if (wr_ptr == LAST_ADDR) begin
              ld_state_d = LD_FULL;
              ram_full_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr + ADDR_W'(1);
            end
          end
        end
        LD_FULL: overflow_d = 1'b1;
        default: ld_state_d = LD_LOAD;
      endcase
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (we_c) mem[MEM_AW'(wr_ptr)] <= rx_data;
  end

  // Registered read port; same-cycle write to the read address returns old data
  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync)            GPout <= '0;
    else if (32'(addr) < DEPTH) GPout <= mem[MEM_AW'(addr)];
    else                        GPout <= '0;
  end

endmodule

// File: tb/tb_serial_frame_loader.sv
module tb_serial_frame_loader;

  localparam int unsigned CPB    = 4;
  localparam int unsigned FLEN   = 4;
  localparam int unsigned NFR    = 2;
  localparam int unsigned DEPTH  = FLEN * NFR;
  localparam int unsigned ADDR_W = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             RxD = 1'b1;
  logic             rearm = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]       GPout;
  logic             RAM_full;
  logic [1:0]       frame_cnt;
  logic             frame_err;
  logic             overflow;

  serial_frame_loader #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (8),
    .FRAME_LEN    (FLEN),
    .NUM_FRAMES   (NFR),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rearm     (rearm),
    .addr      (addr),
    .GPout     (GPout),
    .RAM_full  (RAM_full),
    .frame_cnt (frame_cnt),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rx_pulses = 0;

  // Reference model state
  logic [7:0] shadow [DEPTH];
  int         m_ptr;
  int         m_cnt;
  bit         m_full, m_ferr, m_ovf;

  always @(posedge clk) if (dut.rx_valid) rx_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m_ptr = 0; m_cnt = 0; m_full = 0; m_ferr = 0; m_ovf = 0;
  endtask

  // Expected effect of one received character on the loader
  task automatic model_char(input logic [7:0] d, input bit good);
    if (m_full) m_ovf = 1;
    else if (!good) m_ferr = 1;
    else begin
      shadow[m_ptr] = d;
      sb.push_back('{a: ADDR_W'(m_ptr), d: d});
      m_ptr++;
      if (m_ptr % FLEN == 0) m_cnt++;
      if (m_ptr == DEPTH) m_full = 1;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop);
    RxD = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = d[i]; cyc(CPB);
    end
    RxD = stop; cyc(CPB);
    RxD = 1'b1; cyc(8);
  endtask

  // mode 0: plain, 1: rearm on the rx_valid cycle, 2: read-during-write check
  task automatic send_char(input logic [7:0] d, input logic stop, input int mode,
                           input logic [7:0] old_d);
    bit seen;
    seen = 0;
    fork
      send_bits(d, stop);
      begin
        for (int i = 0; i < 200 && !seen; i++) begin
          cyc(1);
          if (dut.rx_valid) seen = 1;
        end
        if (!seen) chk("rx_valid_timeout", 0, 1);
        else if (mode == 1) begin
          rearm = 1'b1; cyc(1); rearm = 1'b0;
        end else if (mode == 2) begin
          cyc(1); chk("rbw_old", 32'(GPout), 32'(old_d));
          cyc(1); chk("rbw_new", 32'(GPout), 32'(d));
        end
      end
    join
    if (mode == 1) model_clear();
    else model_char(d, stop);
  endtask

  task automatic check_flags(input string tag);
    chk({tag, "_full"},  32'(RAM_full),  32'(m_full));
    chk({tag, "_fcnt"},  32'(frame_cnt), 32'(m_cnt));
    chk({tag, "_ferr"},  32'(frame_err), 32'(m_ferr));
    chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
  endtask

  task automatic read_chk(input string tag, input int a, input logic [7:0] exp);
    addr = ADDR_W'(a); cyc(1);
    chk(tag, 32'(GPout), 32'(exp));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      addr = e.a; cyc(1);
      chk($sformatf("rd@%0d", e.a), 32'(GPout), 32'(e.d));
    end
  endtask

  task automatic do_rearm();
    rearm = 1'b1; cyc(1); rearm = 1'b0; cyc(1);
    model_clear();
  endtask

  initial begin
    int p0;
    model_clear();
    // Reset state
    cyc(5);
    chk("rst_gpout", 32'(GPout), 0);
    check_flags("rst");
    rst = 1'b1; cyc(5);

    // Single character
    p0 = rx_pulses;
    send_char(8'hA5, 1'b1, 0, 8'h00);
    chk("a5_pulses", 32'(rx_pulses - p0), 1);
    check_flags("a5");
    drain();

    // Fill both frames
    do_rearm();
    for (int i = 0; i < 8; i++) begin
      send_char(8'(i), 1'b1, 0, 8'h00);
      check_flags($sformatf("fill%0d", i));
    end
    chk("fill_full", 32'(RAM_full), 1);
    chk("fill_fcnt", 32'(frame_cnt), 2);
    drain();

    // Overflow when full, plus out-of-range reads
    send_char(8'hFF, 1'b1, 0, 8'h00);
    check_flags("ovf");
    read_chk("ovf_addr0", 0, 8'h00);
    read_chk("oor_8", DEPTH, 8'h00);
    read_chk("oor_511", 511, 8'h00);

    // Framing error keeps pointer and memory; next good char lands in place
    do_rearm();
    send_char(8'h10, 1'b1, 0, 8'h00);
    drain();
    send_char(8'h3C, 1'b0, 0, 8'h00);
    check_flags("ferr");
    read_chk("ferr_mem1", 1, shadow[1]);
    addr = ADDR_W'(1); cyc(2);
    send_char(8'h11, 1'b1, 2, shadow[1]);
    check_flags("after_ferr");
    drain();

    // Rearm coincident with a received character
    send_char(8'h77, 1'b1, 1, 8'h00);
    cyc(1);
    check_flags("rearm_rx");
    read_chk("rearm_nowr", 2, shadow[2]);
    send_char(8'h22, 1'b1, 0, 8'h00);
    check_flags("post_rearm");
    drain();

    // Reset in mid-character
    send_char(8'h99, 1'b0, 0, 8'h00);
    addr = '0; cyc(2);
    RxD = 1'b0; cyc(CPB + 3);
    rst = 1'b0; RxD = 1'b1; cyc(1);
    model_clear();
    chk("midrst_gpout", 32'(GPout), 0);
    check_flags("midrst");
    cyc(2);
    rst = 1'b1; cyc(10);
    read_chk("midrst_kept", 0, 8'h22);
    send_char(8'h5A, 1'b1, 0, 8'h00);
    check_flags("post_rst");
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
